rst_release_seq: RTL and testbench



---
 rtl/rst_release_seq.sv | 144 ++++++++++++++
 tb/tb_rst_release_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_release_seq.sv
// rst_release_seq: ordered reset release sequencer.
//
// Holds every downstream stage reset asserted for HOLD_CYC cycles after rst_n
// deasserts (or after a soft reset is accepted). It then releases stage 0,
// and releases each further stage STAGE_DLY cycles after the previous one.
// A soft reset request over a 4-phase req/ack handshake re-asserts all stages
// and replays the sequence.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset (synchronized upstream)
//   soft_rst_req  soft-reset request, level, 4-phase
//   soft_rst_ack  soft-reset acknowledge, level, 4-phase
//   stage_rst_n   per-stage active-low reset, bit 0 released first
//   seq_done      high once every stage is released
//   seq_cnt       (RST_RELEASE_SEQ_STATUS_EN only) saturating count of completed sequences
//
// Optional feature macro: RST_RELEASE_SEQ_STATUS_EN adds the seq_cnt status output.

module rst_release_seq #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned HOLD_CYC   = 4,
  parameter int unsigned STAGE_DLY  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_rst_req,
  output logic                  soft_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done
`ifdef RST_RELEASE_SEQ_STATUS_EN
  ,
  output logic [7:0]            seq_cnt
`endif
);

  localparam int unsigned MaxCyc = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
  localparam int unsigned CntW   = (MaxCyc < 1) ? 1 : $clog2(MaxCyc + 1);
  // One extra code so idx can point one past the last stage once DONE.
  localparam int unsigned IdxW   = $clog2(NUM_STAGES + 1);

  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] StageLast = CntW'(STAGE_DLY - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_stages
    $error("rst_release_seq: NUM_STAGES must be within 1..16");
  end
  if (HOLD_CYC == 0) begin : g_bad_hold
    $error("rst_release_seq: HOLD_CYC must be >= 1");
  end
  if (STAGE_DLY == 0) begin : g_bad_dly
    $error("rst_release_seq: STAGE_DLY must be >= 1");
  end

  typedef enum logic [1:0] {
    StHold,
    StRelease,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;

`ifdef RST_RELEASE_SEQ_STATUS_EN
  logic seq_done_rise;
  assign seq_done_rise = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHold;
      cnt_q        <= '0;
      idx_q        <= '0;
      stage_rst_n  <= '0;
      seq_done     <= 1'b0;
      soft_rst_ack <= 1'b0;
`ifdef RST_RELEASE_SEQ_STATUS_EN
      seq_cnt      <= '0;
`endif
    end else if (soft_rst_req && !soft_rst_ack) begin
      // Accept: restart from HOLD regardless of the current state.
      state_q      <= StHold;
      cnt_q        <= '0;
      idx_q        <= '0;
      stage_rst_n  <= '0;
      seq_done     <= 1'b0;
      soft_rst_ack <= 1'b1;
    end else begin
      // Ack follows req low; the release sequence never waits for it.
      if (!soft_rst_req) begin
        soft_rst_ack <= 1'b0;
      end
      case (state_q)
        StHold: begin
          if (cnt_q == HoldLast) begin
            stage_rst_n[0] <= 1'b1;
            idx_q          <= IdxW'(1);
            cnt_q          <= '0;
            if (NUM_STAGES == 1) begin
              state_q  <= StDone;
              seq_done <= 1'b1;
`ifdef RST_RELEASE_SEQ_STATUS_EN
              if (seq_done_rise && seq_cnt != 8'hff) seq_cnt <= seq_cnt + 8'd1;
`endif
            end else begin
              state_q <= StRelease;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (cnt_q == StageLast) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
              if (idx_q == IdxW'(i)) stage_rst_n[i] <= 1'b1;
            end
            cnt_q <= '0;
            idx_q <= idx_q + 1'b1;
            if (idx_q == LastIdx) begin
              state_q  <= StDone;
              seq_done <= 1'b1;
`ifdef RST_RELEASE_SEQ_STATUS_EN
              if (seq_done_rise && seq_cnt != 8'hff) seq_cnt <= seq_cnt + 8'd1;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          // All outputs hold until the next reset or soft reset.
        end
        default: begin
          state_q <= StHold;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_release_seq.sv
// Testbench for rst_release_seq. Two instances share clock and rst_n:
// dut0 uses default parameters, dut1 uses NUM_STAGES=1, HOLD_CYC=1, STAGE_DLY=1.
// Expected outputs come from an edge-count model: stage k is released once
// HOLD_CYC + k*STAGE_DLY edges have passed since the last (soft) reset.
module tb_rst_release_seq;

  localparam int N0 = 3, H0 = 4, D0 = 3;
  localparam int N1 = 1, H1 = 1, D1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0, req1;
  logic          ack0, ack1;
  logic          done0, done1;
  logic [N0-1:0] st0;
  logic [N1-1:0] st1;
`ifdef RST_RELEASE_SEQ_STATUS_EN
  logic [7:0]    cnt0, cnt1;
`endif

  rst_release_seq #(
    .NUM_STAGES(N0),
    .HOLD_CYC  (H0),
    .STAGE_DLY (D0)
  ) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .soft_rst_req(req0),
    .soft_rst_ack(ack0),
    .stage_rst_n (st0),
    .seq_done    (done0)
`ifdef RST_RELEASE_SEQ_STATUS_EN
    ,
    .seq_cnt     (cnt0)
`endif
  );

  rst_release_seq #(
    .NUM_STAGES(N1),
    .HOLD_CYC  (H1),
    .STAGE_DLY (D1)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .soft_rst_req(req1),
    .soft_rst_ack(ack1),
    .stage_rst_n (st1),
    .seq_done    (done1)
`ifdef RST_RELEASE_SEQ_STATUS_EN
    ,
    .seq_cnt     (cnt1)
`endif
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_no = 0;
  // Model state: edges since the last restart, ack level, done history, count.
  int   e0, e1;
  logic ack0_m, ack1_m;
  logic dprev0, dprev1;
  int   cnt0_m, cnt1_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] exp_st(input int e, input int n, input int h, input int d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++) begin
      if (e >= h + k * d) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic exp_dn(input int e, input int n, input int h, input int d);
    return e >= h + (n - 1) * d;
  endfunction

  task automatic model_upd(input logic req, inout int e, inout logic ack);
    if (req && !ack) begin
      e   = 0;
      ack = 1'b1;
    end else begin
      if (!req) ack = 1'b0;
      e++;
    end
  endtask

  task automatic check_all();
    chk("d0_stage", 32'(st0), exp_st(e0, N0, H0, D0));
    chk("d0_done", 32'(done0), 32'(exp_dn(e0, N0, H0, D0)));
    chk("d0_ack", 32'(ack0), 32'(ack0_m));
    chk("d1_stage", 32'(st1), exp_st(e1, N1, H1, D1));
    chk("d1_done", 32'(done1), 32'(exp_dn(e1, N1, H1, D1)));
    chk("d1_ack", 32'(ack1), 32'(ack1_m));
`ifdef RST_RELEASE_SEQ_STATUS_EN
    chk("d0_cnt", 32'(cnt0), 32'(cnt0_m));
    chk("d1_cnt", 32'(cnt1), 32'(cnt1_m));
`endif
  endtask

  task automatic step();
    logic dn;
    @(posedge clk);
    edge_no++;
    model_upd(req0, e0, ack0_m);
    model_upd(req1, e1, ack1_m);
    dn = exp_dn(e0, N0, H0, D0);
    if (dn && !dprev0 && cnt0_m < 255) cnt0_m++;
    dprev0 = dn;
    dn = exp_dn(e1, N1, H1, D1);
    if (dn && !dprev1 && cnt1_m < 255) cnt1_m++;
    dprev1 = dn;
    #1;
    check_all();
  endtask

  // Called between edges; pulses rst_n low and checks the asynchronous clear.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    e0 = 0; e1 = 0;
    ack0_m = 1'b0; ack1_m = 1'b0;
    dprev0 = 1'b0; dprev1 = 1'b0;
    cnt0_m = 0; cnt1_m = 0;
    check_all();
    #1;
    rst_n   = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    #1;
    apply_reset();

    // Power-on sequence.
    step();
    chk("plan_d1_edge1_stage", 32'(st1), 32'h1);
    chk("plan_d1_edge1_done", 32'(done1), 32'h1);
    while (edge_no < 4) step();
    chk("plan_edge4", 32'(st0), 32'b001);
    while (edge_no < 7) step();
    chk("plan_edge7", 32'(st0), 32'b011);
    while (edge_no < 10) step();
    chk("plan_edge10_stage", 32'(st0), 32'b111);
    chk("plan_edge10_done", 32'(done0), 32'h1);

    // Soft reset after DONE, req held 5 cycles.
    while (edge_no < 19) step();
    req0 = 1'b1;
    step();
    chk("plan_sr_edge20_stage", 32'(st0), 32'b000);
    chk("plan_sr_edge20_ack", 32'(ack0), 32'h1);
    while (edge_no < 24) step();
    req0 = 1'b0;
    chk("plan_sr_edge24", 32'(st0), 32'b001);
    step();
    chk("plan_sr_ack_fall", 32'(ack0), 32'h0);
    while (edge_no < 30) step();
    chk("plan_sr_edge30", 32'(st0), 32'b111);

    // Req held high for 50 cycles: exactly one restart.
    req0 = 1'b1;
    repeat (50) step();
    chk("plan_hold50_done", 32'(done0), 32'h1);
    chk("plan_hold50_ack", 32'(ack0), 32'h1);
    req0 = 1'b0;
    repeat (3) step();

    // Soft reset mid-RELEASE at edge 8.
    apply_reset();
    while (edge_no < 7) step();
    req0 = 1'b1;
    step();
    chk("plan_mid_edge8", 32'(st0), 32'b000);
    req0 = 1'b0;
    while (edge_no < 12) step();
    chk("plan_mid_edge12", 32'(st0), 32'b001);
    repeat (12) step();

    // rst_n pulse at edge 6.
    apply_reset();
    while (edge_no < 6) step();
    apply_reset();
    repeat (3) step();
    chk("plan_rst_edge3", 32'(st0), 32'b000);
    step();
    chk("plan_rst_edge4", 32'(st0), 32'b001);
    repeat (8) step();

    // 300 soft resets on the single-stage instance.
    for (int i = 0; i < 300; i++) begin
      req1 = 1'b1;
      step();
      req1 = 1'b0;
      step();
    end
`ifdef RST_RELEASE_SEQ_STATUS_EN
    chk("plan_seq_cnt_sat", 32'(cnt1), 32'd255);
`endif

    // Randomized req toggling with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) req0 = ~req0;
      if ($urandom_range(7) == 0) req1 = ~req1;
      if ($urandom_range(199) == 0) apply_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
